// File: rtl/rv32_pkg.sv
// Shared constants for the RV32 pipeline: result-source encodings,
// instruction register-field positions and the bubble encoding.
package rv32_pkg;

  // result_source encodings; 3'b100..3'b111 are reserved and select the ALU
  localparam logic [2:0] RES_ALU = 3'b000;
  localparam logic [2:0] RES_MEM = 3'b001;
  localparam logic [2:0] RES_PC4 = 3'b010;
  localparam logic [2:0] RES_FPU = 3'b011;

  // LSB position of each 5-bit register field inside an instruction word
  localparam logic [4:0] RD_LSB  = 5'd7;
  localparam logic [4:0] RS1_LSB = 5'd15;
  localparam logic [4:0] RS2_LSB = 5'd20;
  localparam logic [4:0] RS3_LSB = 5'd27;

  // Instruction word that marks an empty pipeline slot
  localparam logic [31:0] BUBBLE_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/rv32_w_instret_counter.sv
// 64-bit retired-instruction counter with independent CSR loads of each
// half. Any load in a cycle suppresses the increment for the whole counter.
module rv32_w_instret_counter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        retire_i,
  input  logic        load_lo_i,
  input  logic        load_hi_i,
  input  logic [31:0] load_data_i,
  output logic [63:0] count_o
);

  // Loads take priority over counting; the +1 is a full 64-bit add so the
  // low-half carry reaches the high half in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_o <= 64'd0;
    end else if (load_lo_i || load_hi_i) begin
      if (load_lo_i) count_o[31:0]  <= load_data_i;
      if (load_hi_i) count_o[63:32] <= load_data_i;
    end else if (retire_i) begin
      count_o <= count_o + 64'd1;
    end
  end

endmodule

// File: rtl/rv32_writeback.sv
// Writeback stage: selects the result, registers the integer and FP register
// file write ports, drives the decode bypass compare and counts retirements.
//
// Write-port protocol: each *_write_enable_o is a one-cycle valid qualifying
// its address/data registers in the same cycle. There is no ready; the
// register file always accepts. Address and data are meaningful only while
// the matching enable is high.
module rv32_writeback
  import rv32_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        reg_write_i,
  input  logic        fp_reg_write_i,
  input  logic [2:0]  result_source_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] fpu_result_i,
  input  logic [31:0] decode_instr_i,
  input  logic        instret_load_lo_i,
  input  logic        instret_load_hi_i,
  input  logic [31:0] instret_load_data_i,
  output logic        rf_write_enable_o,
  output logic [4:0]  rf_write_addr_o,
  output logic [31:0] rf_write_data_o,
  output logic        fp_write_enable_o,
  output logic [4:0]  fp_write_addr_o,
  output logic [31:0] fp_write_data_o,
  output logic        int_fwd_rs1_o,
  output logic        int_fwd_rs2_o,
  output logic        fp_fwd_rs1_o,
  output logic        fp_fwd_rs2_o,
  output logic        fp_fwd_rs3_o,
  output logic [63:0] instret_o
);

  logic [31:0] result;
  logic [4:0]  rd;
  logic        retire;

  assign rd     = instr_i[RD_LSB +: 5];
  assign retire = !stall_i && (instr_i != BUBBLE_INSTR);

  // Result mux; reserved encodings fall back to the ALU result
  always_comb begin
    result = alu_result_i;
    case (result_source_i)
      RES_ALU: result = alu_result_i;
      RES_MEM: result = read_data_i;
      RES_PC4: result = pc_next_i;
      RES_FPU: result = fpu_result_i;
      default: result = alu_result_i;
    endcase
  end

  // Write-port registers: capture on a retiring instruction, otherwise drop
  // the enables and hold address/data. x0 writes are masked here so the
  // bypass compare can never hit on x0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_write_enable_o <= 1'b0;
      rf_write_addr_o   <= 5'd0;
      rf_write_data_o   <= 32'd0;
      fp_write_enable_o <= 1'b0;
      fp_write_addr_o   <= 5'd0;
      fp_write_data_o   <= 32'd0;
    end else if (retire) begin
      rf_write_enable_o <= reg_write_i && (rd != 5'd0);
      rf_write_addr_o   <= rd;
      rf_write_data_o   <= result;
      fp_write_enable_o <= fp_reg_write_i;
      fp_write_addr_o   <= rd;
      fp_write_data_o   <= result;
    end else begin
      rf_write_enable_o <= 1'b0;
      fp_write_enable_o <= 1'b0;
    end
  end

  // Bypass compare against the instruction currently in decode
  assign int_fwd_rs1_o = rf_write_enable_o && (rf_write_addr_o == decode_instr_i[RS1_LSB +: 5]);
  assign int_fwd_rs2_o = rf_write_enable_o && (rf_write_addr_o == decode_instr_i[RS2_LSB +: 5]);
  assign fp_fwd_rs1_o  = fp_write_enable_o && (fp_write_addr_o == decode_instr_i[RS1_LSB +: 5]);
  assign fp_fwd_rs2_o  = fp_write_enable_o && (fp_write_addr_o == decode_instr_i[RS2_LSB +: 5]);
  assign fp_fwd_rs3_o  = fp_write_enable_o && (fp_write_addr_o == decode_instr_i[RS3_LSB +: 5]);

  rv32_w_instret_counter u_instret (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .retire_i    (retire),
    .load_lo_i   (instret_load_lo_i),
    .load_hi_i   (instret_load_hi_i),
    .load_data_i (instret_load_data_i),
    .count_o     (instret_o)
  );

endmodule

// File: tb/tb_rv32_writeback.sv
// Self-checking bench for rv32_writeback: directed scenarios plus random
// traffic, checked by a per-cycle scoreboard fed from a reference model.
module tb_rv32_writeback;

  localparam int EW = 145;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic        fp_reg_write_i = 1'b0;
  logic [2:0]  result_source_i = 3'd0;
  logic [31:0] alu_result_i = 32'd0;
  logic [31:0] read_data_i = 32'd0;
  logic [31:0] instr_i = 32'd0;
  logic [31:0] pc_next_i = 32'd0;
  logic [31:0] fpu_result_i = 32'd0;
  logic [31:0] decode_instr_i = 32'd0;
  logic        instret_load_lo_i = 1'b0;
  logic        instret_load_hi_i = 1'b0;
  logic [31:0] instret_load_data_i = 32'd0;
  logic        rf_write_enable_o;
  logic [4:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;
  logic        fp_write_enable_o;
  logic [4:0]  fp_write_addr_o;
  logic [31:0] fp_write_data_o;
  logic        int_fwd_rs1_o;
  logic        int_fwd_rs2_o;
  logic        fp_fwd_rs1_o;
  logic        fp_fwd_rs2_o;
  logic        fp_fwd_rs3_o;
  logic [63:0] instret_o;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];

  // reference model state: what the write ports / counter should hold
  logic        m_rf_en = 1'b0;
  logic [4:0]  m_rf_addr = 5'd0;
  logic [31:0] m_rf_data = 32'd0;
  logic        m_fp_en = 1'b0;
  logic [4:0]  m_fp_addr = 5'd0;
  logic [31:0] m_fp_data = 32'd0;
  logic [63:0] m_instret = 64'd0;

  rv32_writeback dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .stall_i             (stall_i),
    .reg_write_i         (reg_write_i),
    .fp_reg_write_i      (fp_reg_write_i),
    .result_source_i     (result_source_i),
    .alu_result_i        (alu_result_i),
    .read_data_i         (read_data_i),
    .instr_i             (instr_i),
    .pc_next_i           (pc_next_i),
    .fpu_result_i        (fpu_result_i),
    .decode_instr_i      (decode_instr_i),
    .instret_load_lo_i   (instret_load_lo_i),
    .instret_load_hi_i   (instret_load_hi_i),
    .instret_load_data_i (instret_load_data_i),
    .rf_write_enable_o   (rf_write_enable_o),
    .rf_write_addr_o     (rf_write_addr_o),
    .rf_write_data_o     (rf_write_data_o),
    .fp_write_enable_o   (fp_write_enable_o),
    .fp_write_addr_o     (fp_write_addr_o),
    .fp_write_data_o     (fp_write_data_o),
    .int_fwd_rs1_o       (int_fwd_rs1_o),
    .int_fwd_rs2_o       (int_fwd_rs2_o),
    .fp_fwd_rs1_o        (fp_fwd_rs1_o),
    .fp_fwd_rs2_o        (fp_fwd_rs2_o),
    .fp_fwd_rs3_o        (fp_fwd_rs3_o),
    .instret_o           (instret_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rs3);
    return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] pick(input logic [2:0] src, input logic [31:0] alu,
                                       input logic [31:0] mem, input logic [31:0] pc4,
                                       input logic [31:0] fpu);
    if (src == 3'd1) return mem;
    if (src == 3'd2) return pc4;
    if (src == 3'd3) return fpu;
    return alu;
  endfunction

  // Reference model advance at a rising edge, from the inputs of that cycle
  task automatic model_edge();
    logic [63:0] mask;
    if (!stall_i && instr_i != 32'h0) begin
      m_rf_en   = reg_write_i && (instr_i[11:7] != 5'd0);
      m_fp_en   = fp_reg_write_i;
      m_rf_addr = instr_i[11:7];
      m_fp_addr = instr_i[11:7];
      m_rf_data = pick(result_source_i, alu_result_i, read_data_i, pc_next_i, fpu_result_i);
      m_fp_data = m_rf_data;
    end else begin
      m_rf_en = 1'b0;
      m_fp_en = 1'b0;
    end
    mask = {{32{instret_load_hi_i}}, {32{instret_load_lo_i}}};
    if (mask != 64'd0)
      m_instret = (m_instret & ~mask) | ({instret_load_data_i, instret_load_data_i} & mask);
    else if (!stall_i && instr_i != 32'h0)
      m_instret = m_instret + 64'd1;
  endtask

  task automatic model_reset();
    m_rf_en = 1'b0; m_rf_addr = 5'd0; m_rf_data = 32'd0;
    m_fp_en = 1'b0; m_fp_addr = 5'd0; m_fp_data = 32'd0;
    m_instret = 64'd0;
  endtask

  // ---------------- driver ----------------
  // Called shortly after a rising edge: drives one cycle of inputs, queues
  // the outputs expected during this cycle, then advances to the next edge.
  task automatic step(input logic stall, input logic rw, input logic fw,
                      input logic [2:0] src, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [31:0] pc4,
                      input logic [31:0] fpu, input logic [31:0] instr,
                      input logic [31:0] dec, input logic ld_lo,
                      input logic ld_hi, input logic [31:0] ld_d);
    logic [4:0] fwd;
    stall_i = stall; reg_write_i = rw; fp_reg_write_i = fw;
    result_source_i = src; alu_result_i = alu; read_data_i = mem;
    pc_next_i = pc4; fpu_result_i = fpu; instr_i = instr;
    decode_instr_i = dec; instret_load_lo_i = ld_lo;
    instret_load_hi_i = ld_hi; instret_load_data_i = ld_d;
    fwd[4] = m_rf_en && (m_rf_addr == dec[19:15]);
    fwd[3] = m_rf_en && (m_rf_addr == dec[24:20]);
    fwd[2] = m_fp_en && (m_fp_addr == dec[19:15]);
    fwd[1] = m_fp_en && (m_fp_addr == dec[24:20]);
    fwd[0] = m_fp_en && (m_fp_addr == dec[31:27]);
    exp_q.push_back({m_rf_en, m_rf_addr, m_rf_data, m_fp_en, m_fp_addr,
                     m_fp_data, m_instret, fwd});
    @(posedge clk_i);
    #1;
    model_edge();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_en"}, 64'(rf_write_enable_o), 64'd0);
    chk({tag, "_rf_addr"}, 64'(rf_write_addr_o), 64'd0);
    chk({tag, "_rf_data"}, 64'(rf_write_data_o), 64'd0);
    chk({tag, "_fp_en"}, 64'(fp_write_enable_o), 64'd0);
    chk({tag, "_fp_addr"}, 64'(fp_write_addr_o), 64'd0);
    chk({tag, "_fp_data"}, 64'(fp_write_data_o), 64'd0);
    chk({tag, "_fwd"}, 64'({int_fwd_rs1_o, int_fwd_rs2_o, fp_fwd_rs1_o,
                            fp_fwd_rs2_o, fp_fwd_rs3_o}), 64'd0);
    chk({tag, "_instret"}, instret_o, 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    if (rst_n_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_rf_en",   64'(rf_write_enable_o), 64'(e[144]));
      chk("sb_rf_addr", 64'(rf_write_addr_o),   64'(e[143:139]));
      chk("sb_rf_data", 64'(rf_write_data_o),   64'(e[138:107]));
      chk("sb_fp_en",   64'(fp_write_enable_o), 64'(e[106]));
      chk("sb_fp_addr", 64'(fp_write_addr_o),   64'(e[105:101]));
      chk("sb_fp_data", 64'(fp_write_data_o),   64'(e[100:69]));
      chk("sb_instret", instret_o,              e[68:5]);
      chk("sb_fwd", 64'({int_fwd_rs1_o, int_fwd_rs2_o, fp_fwd_rs1_o,
                         fp_fwd_rs2_o, fp_fwd_rs3_o}), 64'(e[4:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] saved;
    logic [4:0]  last_rd;
    logic [4:0]  r_rd, r1, r2, r3;
    logic [31:0] ins;

    // reset held across edges: everything must read zero
    repeat (2) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    rst_n_i = 1'b1;
    model_reset();

    // load writeback to x5
    step(0, 1, 0, 3'd1, 32'h1111, 32'hDEADBEEF, 32'h4, 32'h0, mk(5, 0, 0, 0), 32'h0, 0, 0, 0);
    chk("load_rf_en", 64'(rf_write_enable_o), 64'd1);
    chk("load_rf_addr", 64'(rf_write_addr_o), 64'd5);
    chk("load_rf_data", 64'(rf_write_data_o), 64'hDEADBEEF);
    chk("load_instret", instret_o, 64'd1);

    // x0 is never written but still retires
    step(0, 1, 0, 3'd0, 32'h1234, 32'h0, 32'h0, 32'h0, mk(0, 1, 2, 3), 32'h0, 0, 0, 0);
    chk("x0_rf_en", 64'(rf_write_enable_o), 64'd0);
    chk("x0_instret", instret_o, 64'd2);

    // f0 is writable
    step(0, 0, 1, 3'd3, 32'h0, 32'h0, 32'h0, 32'h3F800000, mk(0, 4, 5, 6), 32'h0, 0, 0, 0);
    chk("f0_fp_en", 64'(fp_write_enable_o), 64'd1);
    chk("f0_fp_addr", 64'(fp_write_addr_o), 64'd0);
    chk("f0_fp_data", 64'(fp_write_data_o), 64'h3F800000);

    // JAL to x7, decode reads x7 on both sources
    step(0, 1, 0, 3'd2, 32'h0, 32'h0, 32'h104, 32'h0, mk(7, 0, 0, 0), 32'h0, 0, 0, 0);
    decode_instr_i = mk(1, 7, 7, 0);
    #1;
    chk("byp_int_rs1", 64'(int_fwd_rs1_o), 64'd1);
    chk("byp_int_rs2", 64'(int_fwd_rs2_o), 64'd1);
    chk("byp_int_fp_quiet", 64'({fp_fwd_rs1_o, fp_fwd_rs2_o, fp_fwd_rs3_o}), 64'd0);
    chk("byp_int_data", 64'(rf_write_data_o), 64'h104);

    // FP write to f3, decode has f3 only as rs3
    step(0, 0, 1, 3'd3, 32'h0, 32'h0, 32'h0, 32'h40490FDB, mk(3, 0, 0, 0), 32'h0, 0, 0, 0);
    decode_instr_i = mk(0, 1, 2, 3);
    #1;
    chk("byp_fp_rs3", 64'(fp_fwd_rs3_o), 64'd1);
    chk("byp_fp_rs12", 64'({fp_fwd_rs1_o, fp_fwd_rs2_o}), 64'd0);
    chk("byp_fp_int_quiet", 64'({int_fwd_rs1_o, int_fwd_rs2_o}), 64'd0);

    // both requests in one instruction
    step(0, 1, 1, 3'd3, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, mk(9, 0, 0, 0), 32'h0, 0, 0, 0);
    chk("both_en", 64'({rf_write_enable_o, fp_write_enable_o}), 64'h3);
    chk("both_data", {rf_write_data_o, fp_write_data_o}, 64'hCAFEF00D_CAFEF00D);

    // three stalled cycles: no writes, counter holds, data holds
    saved = m_instret;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 3'd0, 32'h55 + 32'(i), 32'h0, 32'h0, 32'h0, mk(10, 0, 0, 0), 32'h0, 0, 0, 0);
      chk("stall_en", 64'({rf_write_enable_o, fp_write_enable_o}), 64'd0);
    end
    chk("stall_instret", instret_o, saved);
    chk("stall_data_hold", 64'(rf_write_data_o), 64'hCAFEF00D);

    // bubble: no write, no count
    step(0, 1, 1, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    chk("bubble_en", 64'({rf_write_enable_o, fp_write_enable_o}), 64'd0);
    chk("bubble_instret", instret_o, saved);

    // counter: carry from low to high half
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 32'hFFFFFFFF);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h00000001);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, mk(0, 0, 0, 0), 32'h0, 0, 0, 0);
    chk("cnt_carry", instret_o, 64'h2_0000_0000);
    // load beats a coincident retire
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, mk(0, 0, 0, 0), 32'h0, 1, 0, 32'h5);
    chk("cnt_load_lo", instret_o, 64'h2_0000_0005);
    // both halves loaded, then wrap
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, mk(0, 0, 0, 0), 32'h0, 1, 1, 32'hFFFFFFFF);
    chk("cnt_all_ones", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, mk(0, 0, 0, 0), 32'h0, 0, 0, 0);
    chk("cnt_wrap", instret_o, 64'd0);

    // asynchronous reset while a write enable is high
    step(0, 1, 1, 3'd0, 32'hABCD, 32'h0, 32'h0, 32'h0, mk(4, 0, 0, 0), 32'h0, 0, 0, 0);
    chk("pre_rst_en", 64'(rf_write_enable_o), 64'd1);
    decode_instr_i = mk(0, 4, 4, 4);
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();

    // random traffic
    last_rd = 5'd1;
    for (int n = 0; n < 400; n++) begin
      r_rd = 5'($urandom_range(0, 31));
      ins  = ($urandom_range(0, 9) == 0) ? 32'h0 : (mk(r_rd, 5'($urandom), 5'($urandom), 5'($urandom)) ^ {12'h0, 20'($urandom) & 20'hF_F000});
      r1 = ($urandom_range(0, 1) == 1) ? last_rd : 5'($urandom);
      r2 = ($urandom_range(0, 1) == 1) ? last_rd : 5'($urandom);
      r3 = ($urandom_range(0, 1) == 1) ? last_rd : 5'($urandom);
      step(($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 3'($urandom),
           $urandom, $urandom, $urandom, $urandom, ins, mk(5'($urandom), r1, r2, r3),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), $urandom);
      last_rd = ins[11:7];
    end

    // let the monitor drain the last entry
    @(posedge clk_i);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32_writeback.md
Name: rv32_writeback

Overview:
- Final pipeline stage, directly downstream of the two-cycle memory stage. Consumes that stage's registered outputs.
- Selects the result per result_source and extracts the destination from instr[11:7].
- Drives registered write ports for the integer and FP register files, with single-cycle bypass to decode.
- Maintains the 64-bit instret counter, loadable by the CSR unit.

Parameters:
- BUBBLE_INSTR, 32'h0000_0000, encoding treated as a pipeline bubble: not retired, no writes.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- stall_i  in  1  hold writeback: no capture, no count
- reg_write_i  in  1  integer RF write request
- fp_reg_write_i  in  1  FP RF write request
- result_source_i  in  3  result select
- alu_result_i  in  32  ALU result
- read_data_i  in  32  formatted load data
- instr_i  in  32  instruction in writeback
- pc_next_i  in  32  PC+4, link value
- fpu_result_i  in  32  FPU result
- decode_instr_i  in  32  instruction in decode, for bypass compare
- instret_load_lo_i  in  1  CSR write of instret[31:0]
- instret_load_hi_i  in  1  CSR write of instret[63:32]
- instret_load_data_i  in  32  CSR write data
- rf_write_enable_o  out  1  integer RF write enable
- rf_write_addr_o  out  5  integer RF write address
- rf_write_data_o  out  32  integer RF write data
- fp_write_enable_o  out  1  FP RF write enable
- fp_write_addr_o  out  5  FP RF write address
- fp_write_data_o  out  32  FP RF write data
- int_fwd_rs1_o, int_fwd_rs2_o  out  1 each  bypass hit on integer rs1/rs2
- fp_fwd_rs1_o, fp_fwd_rs2_o, fp_fwd_rs3_o  out  1 each  bypass hit on FP rs1/rs2/rs3
- instret_o  out  64  retired-instruction count

Behaviour:
- Result mux (combinational, cycle N), keyed on result_source_i:
  - 000 ALU
  - 001 read_data
  - 010 pc_next
  - 011 fpu_result
  - 100-111 reserved, select ALU
- Destination rd = instr_i[11:7]. The same selected result feeds both ports.
- Write-port capture: at the rising edge ending cycle N, if !stall_i && instr_i != BUBBLE_INSTR:
  - rf_write_enable_o <= reg_write_i && rd != 0 (x0 never written)
  - fp_write_enable_o <= fp_reg_write_i; f0 is writable
  - address and data registers always capture
- If stall_i or a bubble: both enables <= 0; address and data hold.
- Latency: result captured at the edge ending N, presented during N+1, written by the RF at the edge ending N+1.
- Both requests set: both ports fire with the same data. This is legal for FP-to-int moves; no priority.
- Bypass (combinational, during N+1), same for the data outputs of both files:
  - int_fwd_rsK_o = rf_write_enable_o && rf_write_addr_o == decode_instr_i[19:15] (rs1) / [24:20] (rs2)
  - fp_fwd_rs1/2/3 same pattern using fp_write_enable_o and [19:15]/[24:20]/[31:27]
  - Decode uses rf_write_data_o / fp_write_data_o on a hit.
  - x0 can never hit because the enable is already masked.
- instret, updated at the rising edge:
  - A load of either half has priority. The loaded half takes instret_load_data_i.
  - While a load is pending, the increment is suppressed for the whole counter in that cycle.
  - Otherwise, increment by 1 when !stall_i && instr_i != BUBBLE_INSTR.
  - Wraps 2^64-1 -> 0. The carry from the low half propagates within the cycle.
  - Both halves loaded in the same cycle: both take the same data.
- Reset (async, any time, including mid-stall): all write-port registers, enables and instret_o -> 0. Bypass outputs are therefore 0.
- First capture occurs on the first rising edge after rst_n_i deasserts.

Decomposition:
- Shared rv32_pkg holds:
  - result_source encoding constants RES_ALU/RES_MEM/RES_PC4/RES_FPU
  - instr field position constants (rd, rs1, rs2, rs3)
  - BUBBLE_INSTR default
- One sub-module: rv32_w_instret_counter, holding the 64-bit counter, split load and increment gating.

Test Plan:
- Reset mid-operation: assert rst_n_i low while a write enable is high -> all outputs 0 immediately, no clock needed.
- Load writeback: reg_write=1, result_source=001, read_data=32'hDEADBEEF, rd=5 -> next cycle rf_write_enable_o=1, addr=5, data=DEADBEEF; instret increments by 1.
- x0 and f0: reg_write=1, rd=0, ALU=32'h1234 -> rf_write_enable_o=0 while instret still +1. fp_reg_write=1, rd=0, result_source=011 -> fp_write_enable_o=1, addr=0.
- Bypass: JAL writing x7 with pc_next=32'h104 (result_source=010), decode_instr rs1=7, rs2=7 -> int_fwd_rs1_o=int_fwd_rs2_o=1, data 0x104. FP write to f3 with decode rs3=3 -> fp_fwd_rs3_o=1 only.
- Stall and bubble: stall_i=1 for 3 cycles with a valid instr -> enables 0, instret constant. instr=0 -> no write, no count.
- Counter edges:
  - preload lo=FFFFFFFF, hi=00000001, then retire one -> instret=64'h2_00000000
  - load_lo=5 coincident with a retire -> low half reads 5, no increment
  - all-ones +1 -> 0
